mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port.
- Serialises the two requesters over a variable-latency req/ack memory interface.
- Round-robin on ties; a watchdog aborts hung accesses.
- Drives the pipeline-wide stall that freezes PC and the inter-stage registers while any access is outstanding.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_watchdog.sv | 33 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int unsigned DEFAULT_TIMEOUT = 15;
  localparam int unsigned WD_CNT_W        = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: loaded at each grant, counts down while the memory is silent,
// and flags the last cycle in which an ack can still rescue the access.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic count_en,
  output logic expire
);

  logic [WD_CNT_W-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= WD_CNT_W'(TIMEOUT);
    end else if (clear) begin
      remaining <= '0;
    end else if (count_en && (remaining != '0)) begin
      remaining <= remaining - WD_CNT_W'(1);
    end
  end

  // One remaining cycle means this busy cycle is the final one without an ack.
  assign expire = (remaining == WD_CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one req/ack memory port,
// with round-robin tie breaking, a timeout watchdog and the pipeline stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_BITS-1:0] if_addr,
  output logic [INSTR_W-1:0]   if_rdata,
  output logic                 if_valid,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_valid,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 stall,
  output logic                 err
);

  arb_state_t state, next_state;
  grant_t     last_grant;

  logic busy_i, busy_d, busy;
  logic arb_en, if_eff, d_eff, gnt_i, gnt_d;
  logic wd_expire, abort, finishing;

  assign busy_i    = (state == BUSY_I);
  assign busy_d    = (state == BUSY_D);
  assign busy      = busy_i || busy_d;
  assign abort     = busy && !mem_ack && wd_expire;
  assign finishing = busy && (mem_ack || abort);

  // The port being completed is excluded so it is never re-granted on its own valid.
  assign if_eff = if_req && !if_valid && !busy_i;
  assign d_eff  = d_req && !d_valid && !busy_d;
  assign arb_en = (state == IDLE) || (busy && mem_ack);
  assign gnt_i  = arb_en && if_eff && (!d_eff || (last_grant == GNT_D));
  assign gnt_d  = arb_en && d_eff && (!if_eff || (last_grant == GNT_I));

  assign stall = (if_req && !if_valid) || (d_req && !d_valid);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!busy && !gnt_i && !gnt_d),
    .load     (gnt_i || gnt_d),
    .count_en (busy && !mem_ack),
    .expire   (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (gnt_i) begin
          next_state = BUSY_I;
        end else if (gnt_d) begin
          next_state = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          if (gnt_i) begin
            next_state = BUSY_I;
          end else if (gnt_d) begin
            next_state = BUSY_D;
          end else begin
            next_state = IDLE;
          end
        end else if (abort) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Response pulses, read data capture and the memory-side request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
      last_grant <= GNT_D;
    end else begin
      if_valid <= busy_i && (mem_ack || abort);
      d_valid  <= busy_d && (mem_ack || abort);
      err      <= abort;
      if (busy_i && mem_ack) begin
        if_rdata <= mem_rdata[INSTR_W-1:0];
      end
      if (busy_d && mem_ack && !mem_we) begin
        d_rdata <= mem_rdata;
      end
      if (gnt_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        last_grant <= GNT_I;
      end else if (gnt_d) begin
        mem_req    <= 1'b1;
        mem_we     <= d_we;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        last_grant <= GNT_D;
      end else if (finishing) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_BITS = 6;
  localparam int DATA_W    = 64;
  localparam int INSTR_W   = 32;
  localparam int TIMEOUT   = 15;

  logic                 clk;
  logic                 rst_n;
  logic                 if_req;
  logic [ADDR_BITS-1:0] if_addr;
  logic [INSTR_W-1:0]   if_rdata;
  logic                 if_valid;
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [DATA_W-1:0]    d_wdata;
  logic [DATA_W-1:0]    d_rdata;
  logic                 d_valid;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_ack;
  logic                 stall;
  logic                 err;

  mem_port_arbiter #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W),
    .INSTR_W   (INSTR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_count  = 0;
  int check_count = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: actual=%h expected=%h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [ADDR_BITS-1:0] ia,
                               input logic dr, input logic dw,
                               input logic [ADDR_BITS-1:0] da, input logic [DATA_W-1:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  // Memory responder: acks each new access after a chosen latency, reads/writes mem_arr.
  logic [DATA_W-1:0] mem_arr [64];
  int  fixed_lat = 1;
  bit  stray_en  = 1'b0;
  int  ack_at    = -1;
  bit  prev_req  = 1'b0;
  bit  prev_ack  = 1'b0;

  function automatic int pick_latency();
    int r;
    if (fixed_lat >= 0) return fixed_lat;
    r = int'($urandom_range(0, 19));
    if (r == 0) return TIMEOUT + 5;
    if (r == 1) return TIMEOUT - 1;
    if (r == 2) return TIMEOUT;
    return int'($urandom_range(1, 4));
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_arr[i] = {$urandom, $urandom};
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        mem_ack  = 1'b0;
        ack_at   = -1;
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (mem_req && (!prev_req || prev_ack)) ack_at = cyc + pick_latency();
        if (!mem_req) ack_at = -1;
        mem_ack   = mem_req && (cyc == ack_at);
        mem_rdata = {$urandom, $urandom};
        if (mem_ack) begin
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata = mem_arr[mem_addr];
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        if (!mem_req && stray_en && ($urandom_range(0, 9) == 0)) mem_ack = 1'b1;
      end
    end
  end

  // Transaction-level reference: one access owns the memory from its first
  // request cycle until an ack or until it has waited TIMEOUT cycles.
  int                   m_port  = -1;
  int                   m_start = 0;
  int                   m_last  = 1;
  logic                 exp_if_valid, exp_d_valid, exp_err, exp_mem_req, exp_mem_we;
  logic [ADDR_BITS-1:0] exp_mem_addr;
  logic [DATA_W-1:0]    exp_mem_wdata, exp_d_rdata;
  logic [INSTR_W-1:0]   exp_if_rdata;

  task automatic model_reset();
    m_port        = -1;
    m_last        = 1;
    exp_if_valid  = 1'b0;
    exp_d_valid   = 1'b0;
    exp_err       = 1'b0;
    exp_mem_req   = 1'b0;
    exp_mem_we    = 1'b0;
    exp_mem_addr  = '0;
    exp_mem_wdata = '0;
    exp_d_rdata   = '0;
    exp_if_rdata  = '0;
  endtask

  task automatic model_step();
    bit done, timed_out, can_grant, want_i, want_d;
    int pick;
    done      = (m_port >= 0) && (mem_ack || (cyc - m_start + 1 >= TIMEOUT));
    timed_out = done && !mem_ack;
    if (done && mem_ack) begin
      if (m_port == 0)      exp_if_rdata = mem_rdata[INSTR_W-1:0];
      else if (!exp_mem_we) exp_d_rdata  = mem_rdata;
    end
    can_grant = (m_port < 0) || (done && !timed_out);
    want_i    = if_req && !exp_if_valid && (m_port != 0);
    want_d    = d_req && !exp_d_valid && (m_port != 1);
    pick = -1;
    if (can_grant) begin
      if (want_i && want_d) pick = 1 - m_last;
      else if (want_i)      pick = 0;
      else if (want_d)      pick = 1;
    end
    exp_if_valid = done && (m_port == 0);
    exp_d_valid  = done && (m_port == 1);
    exp_err      = timed_out;
    if (pick == 0) begin
      m_port = 0; m_start = cyc + 1; m_last = 0;
      exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = if_addr; exp_mem_wdata = '0;
    end else if (pick == 1) begin
      m_port = 1; m_start = cyc + 1; m_last = 1;
      exp_mem_req = 1'b1; exp_mem_we = d_we; exp_mem_addr = d_addr; exp_mem_wdata = d_wdata;
    end else if (done) begin
      m_port = -1;
      exp_mem_req = 1'b0;
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    checkOutput("if_valid",  64'(if_valid),  64'(exp_if_valid));
    checkOutput("d_valid",   64'(d_valid),   64'(exp_d_valid));
    checkOutput("err",       64'(err),       64'(exp_err));
    checkOutput("mem_req",   64'(mem_req),   64'(exp_mem_req));
    checkOutput("mem_we",    64'(mem_we),    64'(exp_mem_we));
    checkOutput("mem_addr",  64'(mem_addr),  64'(exp_mem_addr));
    checkOutput("mem_wdata", mem_wdata,      exp_mem_wdata);
    checkOutput("if_rdata",  64'(if_rdata),  64'(exp_if_rdata));
    checkOutput("d_rdata",   d_rdata,        exp_d_rdata);
    checkOutput("stall",     64'(stall),
                64'((if_req && !exp_if_valid) || (d_req && !exp_d_valid)));
    if (rst_n) model_step();
  end

  bit allow_new = 1'b1;

  task automatic drive_random();
    if (!if_req) begin
      if (allow_new && ($urandom_range(0, 2) == 0)) begin
        if_req  = 1'b1;
        if_addr = ADDR_BITS'($urandom);
      end
    end else if (if_valid) begin
      if (allow_new && ($urandom_range(0, 1) == 0)) if_addr = ADDR_BITS'($urandom);
      else                                          if_req  = 1'b0;
    end
    if (!d_req) begin
      if (allow_new && ($urandom_range(0, 2) == 0)) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom);
        d_addr  = ADDR_BITS'($urandom);
        d_wdata = {$urandom, $urandom};
      end
    end else if (d_valid) begin
      if (allow_new && ($urandom_range(0, 1) == 0)) begin
        d_we    = 1'($urandom);
        d_addr  = ADDR_BITS'($urandom);
        d_wdata = {$urandom, $urandom};
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset in the middle of a data access.
    fixed_lat = 1000;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 6'h08, '0);
    tick(3);
    checkOutput("busy_mem_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_d_valid", 64'(d_valid), 64'd0);
    checkOutput("rst_err",     64'(err),     64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // First tie after reset goes to fetch, then the store back-to-back.
    fixed_lat  = 1;
    mem_arr[2] = 64'hFFFF_0000_1357_2468;
    applyStimulus(1'b1, 6'h02, 1'b1, 1'b1, 6'h10, 64'hDEAD);
    tick(1);
    checkOutput("tie_first_addr", 64'(mem_addr), 64'h02);
    checkOutput("tie_first_we",   64'(mem_we),   64'd0);
    tick(2);
    checkOutput("tie_if_valid",  64'(if_valid), 64'd1);
    checkOutput("tie_if_rdata",  64'(if_rdata), 64'h1357_2468);
    checkOutput("tie_b2b_req",   64'(mem_req),  64'd1);
    checkOutput("tie_b2b_addr",  64'(mem_addr), 64'h10);
    checkOutput("tie_b2b_we",    64'(mem_we),   64'd1);
    checkOutput("tie_b2b_wdata", mem_wdata,     64'hDEAD);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 6'h10, 64'hDEAD);
    tick(1);
    checkOutput("tie_d_valid_early", 64'(d_valid), 64'd0);
    tick(1);
    checkOutput("tie_d_valid", 64'(d_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick(1);
    checkOutput("tie_idle_req", 64'(mem_req), 64'd0);

    // Single fetch with a one-cycle memory.
    tick(2);
    mem_arr[4] = 64'h0000_0000_0050_0093;
    applyStimulus(1'b1, 6'h04, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("fetch_stall_c0", 64'(stall), 64'd1);
    tick(2);
    checkOutput("fetch_stall_c2", 64'(stall),    64'd1);
    checkOutput("fetch_valid_c2", 64'(if_valid), 64'd0);
    tick(1);
    checkOutput("fetch_valid_c3", 64'(if_valid), 64'd1);
    checkOutput("fetch_rdata",    64'(if_rdata), 64'h0050_0093);
    checkOutput("fetch_stall_c3", 64'(stall),    64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Load with four wait cycles.
    tick(2);
    fixed_lat  = 4;
    mem_arr[8] = 64'h1234_5678_9ABC_DEF0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 6'h08, '0);
    tick(5);
    checkOutput("load_valid_c5", 64'(d_valid), 64'd0);
    tick(1);
    checkOutput("load_valid_c6", 64'(d_valid), 64'd1);
    checkOutput("load_rdata",    d_rdata,      64'h1234_5678_9ABC_DEF0);
    checkOutput("load_err",      64'(err),     64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick(1);
    checkOutput("load_valid_c7", 64'(d_valid), 64'd0);

    // Memory never answers: abort after TIMEOUT + 1 cycles.
    tick(2);
    fixed_lat = 1000;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 6'h20, '0);
    tick(TIMEOUT);
    checkOutput("to_valid_early", 64'(d_valid), 64'd0);
    checkOutput("to_err_early",   64'(err),     64'd0);
    tick(1);
    checkOutput("to_valid", 64'(d_valid), 64'd1);
    checkOutput("to_err",   64'(err),     64'd1);
    checkOutput("to_rdata", d_rdata,      64'h1234_5678_9ABC_DEF0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick(1);
    checkOutput("to_req_drop", 64'(mem_req), 64'd0);
    checkOutput("to_err_once", 64'(err),     64'd0);

    // Fetch request held through its valid is not re-granted that cycle.
    tick(2);
    fixed_lat = 1;
    applyStimulus(1'b1, 6'h05, 1'b0, 1'b0, '0, '0);
    tick(3);
    checkOutput("rg_valid",     64'(if_valid), 64'd1);
    checkOutput("rg_req_c3",    64'(mem_req),  64'd0);
    tick(1);
    checkOutput("rg_req_c4",    64'(mem_req),  64'd0);
    tick(1);
    checkOutput("rg_req_c5",    64'(mem_req),  64'd1);
    checkOutput("rg_we_c5",     64'(mem_we),   64'd0);
    checkOutput("rg_addr_c5",   64'(mem_addr), 64'h05);
    tick(2);
    checkOutput("rg_valid_2nd", 64'(if_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick(2);

    // Randomized traffic with mixed latencies, timeouts and stray acks.
    fixed_lat = -1;
    stray_en  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick(1);
      drive_random();
    end
    allow_new = 1'b0;
    for (int n = 0; n < 80; n++) begin
      tick(1);
      drive_random();
    end
    stray_en = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
